// File: rtl/ir_seq_pkg.sv
// Shared state encodings and counter widths for the IR capture run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ir_seq_pkg;

  localparam int CNT_W  = 32;
  localparam int FCNT_W = 8;

  typedef enum logic [2:0] {
    ST_STARTUP     = 3'd0,
    ST_CAPTURE     = 3'd1,
    ST_NOTIFY      = 3'd2,
    ST_WAIT_UPLOAD = 3'd3,
    ST_IDLE        = 3'd4,
    ST_FAULT       = 3'd5
  } state_t;

  // Busy covers the whole capture-to-upload span of a burst.
  function automatic logic is_busy(input state_t s);
    return (s == ST_CAPTURE) || (s == ST_NOTIFY) || (s == ST_WAIT_UPLOAD);
  endfunction

endpackage

// File: rtl/ir_capture_sequencer_rise_edge_det.sv
// Rising-edge detector: remembers last cycle's input level.
// Latency: o_rise is high in the same cycle the input first reads high.
// Backpressure: none; the previous-value register samples every cycle.
module rise_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Track the input level from the previous cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/ir_capture_sequencer.sv
// Run controller: settling delay, N-frame burst, done pulse, upload handshake.
// Latency: a qualifying input edge before clock edge k changes state/outputs at k.
// Backpressure: none; outputs are registered levels, abort forces IDLE.
module ir_capture_sequencer
  import ir_seq_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES       = 48000000,
  parameter int unsigned FRAME_COUNT          = 2,
  parameter int unsigned DONE_PULSE_CYCLES    = 6,
  parameter int unsigned FRAME_TIMEOUT_CYCLES = 48000000
) (
  input  logic              iClk,
  input  logic              iRst_N,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iContinuous,
  input  logic              iWr_Frame_Done,
  input  logic              iUpload_Done,
  output logic              oCapture_En,
  output logic              oDDRWriter_En,
  output logic              oWr_Done,
  output logic              oBusy,
  output logic              oTimeout,
  output logic [FCNT_W-1:0] oFrame_Cnt,
  output logic [2:0]        oState
);

  localparam logic [CNT_W-1:0]  LP_START_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LP_PULSE_LAST = CNT_W'(DONE_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LP_WDOG_LAST  = CNT_W'(FRAME_TIMEOUT_CYCLES - 1);
  localparam logic [FCNT_W-1:0] LP_FCNT_MAX   = FCNT_W'(FRAME_COUNT);
  localparam logic [FCNT_W-1:0] LP_FCNT_LAST  = FCNT_W'(FRAME_COUNT - 1);

  logic w_start_rise;
  logic w_frame_rise;
  logic w_upload_rise;

  rise_edge_det u_start_det (
    .i_clk(iClk), .i_rst_n(iRst_N), .i_d(iStart), .o_rise(w_start_rise)
  );
  rise_edge_det u_frame_det (
    .i_clk(iClk), .i_rst_n(iRst_N), .i_d(iWr_Frame_Done), .o_rise(w_frame_rise)
  );
  rise_edge_det u_upload_det (
    .i_clk(iClk), .i_rst_n(iRst_N), .i_d(iUpload_Done), .o_rise(w_upload_rise)
  );

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_nxt;
  logic              r_cap_en;
  logic              r_wr_done;
  logic              r_busy;
  logic              r_timeout;
  logic              w_cap_en_nxt;
  logic              w_wr_done_nxt;
  logic              w_busy_nxt;
  logic              w_timeout_nxt;
  logic              w_abort;

  // Abort is ignored until the settling delay has completed.
  assign w_abort = iAbort && (r_state != ST_STARTUP);

  // Register state, shared counter, frame count and all outputs.
  always_ff @(posedge iClk) begin
    if (!iRst_N) begin
      r_state   <= ST_STARTUP;
      r_cnt     <= '0;
      r_fcnt    <= '0;
      r_cap_en  <= 1'b0;
      r_wr_done <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_cap_en  <= w_cap_en_nxt;
      r_wr_done <= w_wr_done_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state selection; a frame edge beats a same-cycle watchdog expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_STARTUP:     if (r_cnt == LP_START_LAST) w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        if (w_frame_rise) begin
          if (r_fcnt == LP_FCNT_LAST) w_next = ST_NOTIFY;
        end else if (r_cnt == LP_WDOG_LAST) begin
          w_next = ST_FAULT;
        end
      end
      ST_NOTIFY:      if (r_cnt == LP_PULSE_LAST) w_next = ST_WAIT_UPLOAD;
      ST_WAIT_UPLOAD: if (w_upload_rise) w_next = iContinuous ? ST_CAPTURE : ST_IDLE;
      ST_IDLE:        if (w_start_rise) w_next = ST_CAPTURE;
      ST_FAULT:       if (w_start_rise) w_next = ST_CAPTURE;
      default:        w_next = ST_STARTUP;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // Next values of counters and registered outputs, derived from the next state.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_next == r_state) begin
      if ((r_state == ST_STARTUP) || (r_state == ST_NOTIFY) ||
          ((r_state == ST_CAPTURE) && !w_frame_rise)) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    // Frame count restarts on every entry to CAPTURE and is held on abort.
    w_fcnt_nxt = r_fcnt;
    if ((r_state != ST_CAPTURE) && (w_next == ST_CAPTURE)) begin
      w_fcnt_nxt = '0;
    end else if ((r_state == ST_CAPTURE) && w_frame_rise && !w_abort &&
                 (r_fcnt < LP_FCNT_MAX)) begin
      w_fcnt_nxt = r_fcnt + FCNT_W'(1);
    end

    w_cap_en_nxt  = (w_next == ST_CAPTURE);
    w_wr_done_nxt = (w_next == ST_NOTIFY);
    w_busy_nxt    = is_busy(w_next);

    // Timeout is set by a watchdog fault and cleared only by a restart from FAULT.
    w_timeout_nxt = r_timeout;
    if ((r_state == ST_CAPTURE) && (w_next == ST_FAULT)) begin
      w_timeout_nxt = 1'b1;
    end else if ((r_state == ST_FAULT) && (w_next == ST_CAPTURE)) begin
      w_timeout_nxt = 1'b0;
    end
  end

  assign oCapture_En   = r_cap_en;
  assign oDDRWriter_En = r_cap_en;
  assign oWr_Done      = r_wr_done;
  assign oBusy         = r_busy;
  assign oTimeout      = r_timeout;
  assign oFrame_Cnt    = r_fcnt;
  assign oState        = r_state;

endmodule

// File: tb/tb_ir_capture_sequencer.sv
// Bench for ir_capture_sequencer: directed stimulus pushes timed expected output
// snapshots; a monitor pops one entry per observed output change and compares
// both the values and the clock edge at which they appeared.
module tb_ir_capture_sequencer;

  typedef struct packed {
    logic       cap;
    logic       ddr;
    logic       wrd;
    logic       busy;
    logic       tmo;
    logic [7:0] fcnt;
    logic [2:0] st;
  } snap_t;

  typedef struct packed {
    logic [31:0] cyc;
    snap_t       s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic       frame = 1'b0;
  logic       upload = 1'b0;
  logic       cap_en, ddr_en, wr_done, busy, tmo;
  logic [7:0] fcnt;
  logic [2:0] st;

  snap_t       dut_snap;
  exp_t        exp_q[$];
  string       name_q[$];
  int unsigned edge_n = 0;
  int          n_checks = 0;
  int          n_err = 0;
  logic        mon_go = 1'b0;
  logic        tb_done = 1'b0;

  ir_capture_sequencer #(
    .STARTUP_CYCLES(100),
    .FRAME_COUNT(2),
    .DONE_PULSE_CYCLES(6),
    .FRAME_TIMEOUT_CYCLES(1000)
  ) dut (
    .iClk(clk), .iRst_N(rst_n), .iStart(start), .iAbort(abort),
    .iContinuous(cont), .iWr_Frame_Done(frame), .iUpload_Done(upload),
    .oCapture_En(cap_en), .oDDRWriter_En(ddr_en), .oWr_Done(wr_done),
    .oBusy(busy), .oTimeout(tmo), .oFrame_Cnt(fcnt), .oState(st)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  assign dut_snap = {cap_en, ddr_en, wr_done, busy, tmo, fcnt, st};

  function automatic snap_t mk(input logic en, input logic wrd, input logic bsy,
                               input logic to, input logic [7:0] fc, input logic [2:0] s);
    snap_t r;
    r.cap = en; r.ddr = en; r.wrd = wrd; r.busy = bsy; r.tmo = to; r.fcnt = fc; r.st = s;
    return r;
  endfunction

  function automatic snap_t s_cap(input logic [7:0] fc, input logic to);
    return mk(1'b1, 1'b0, 1'b1, to, fc, 3'd1);
  endfunction

  // Expect the outputs to become s at the clock edge rel edges after now.
  task automatic expect_at(input int unsigned rel, input snap_t s, input string nm);
    exp_t e;
    e.cyc = edge_n + rel;
    e.s   = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: one comparison per output change, plus reset state and a final drain check.
  initial begin
    snap_t prev, cur;
    exp_t  e;
    string nm;
    wait (mon_go);
    cur = dut_snap;
    n_checks++;
    if (cur !== mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0)) begin
      n_err++;
      $display("FAIL reset_state got=%h want=%h", cur, 16'h0);
    end
    prev = cur;
    while (!tb_done) begin
      @(negedge clk);
      cur = dut_snap;
      if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change edge=%0d got=%h was=%h", edge_n, cur, prev);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ((cur !== e.s) || (edge_n != e.cyc)) begin
            n_err++;
            $display("FAIL %s got=%h at edge %0d, want=%h at edge %0d",
                     nm, cur, edge_n, e.s, e.cyc);
          end
        end
        prev = cur;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_expectations got=%0d outstanding want=0, first=%s",
               exp_q.size(), name_q[0]);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Directed stimulus.
  initial begin
    step(3);
    mon_go = 1'b1;
    step(1);

    // Settling delay: enables rise on the 100th edge after release.
    rst_n = 1'b1;
    expect_at(100, s_cap(8'd0, 1'b0), "startup_exit");
    step(100);
    step(50);

    // Two frames 300 cycles apart complete a burst.
    frame = 1'b1;
    expect_at(1, s_cap(8'd1, 1'b0), "frame1");
    step(1); frame = 1'b0;
    step(299);
    frame = 1'b1;
    expect_at(1, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 3'd2), "notify_enter");
    expect_at(7, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 3'd3), "notify_width");
    step(1); frame = 1'b0;

    // Upload level rising during NOTIFY and held into WAIT_UPLOAD is ignored.
    upload = 1'b1;
    step(10);
    upload = 1'b0;
    step(5);
    upload = 1'b1;
    expect_at(1, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd4), "upload_to_idle");
    step(2); upload = 1'b0;
    step(3);

    // Start from IDLE, then let the watchdog expire.
    start = 1'b1;
    expect_at(1, s_cap(8'd0, 1'b0), "idle_start");
    expect_at(1001, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'd5), "watchdog_fault");
    step(1); start = 1'b0;
    step(1005);

    // Restart from FAULT clears timeout; a frame edge on the expiry cycle wins.
    start = 1'b1;
    expect_at(1, s_cap(8'd0, 1'b0), "fault_restart");
    step(1); start = 1'b0;
    step(999);
    frame = 1'b1;
    expect_at(1, s_cap(8'd1, 1'b0), "frame_at_expiry");
    step(1); frame = 1'b0;

    // Finish the burst and re-arm continuously on the upload edge.
    step(20);
    cont  = 1'b1;
    frame = 1'b1;
    expect_at(1, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 3'd2), "notify2_enter");
    expect_at(7, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 3'd3), "notify2_width");
    step(1); frame = 1'b0;
    step(10);
    upload = 1'b1;
    expect_at(1, s_cap(8'd0, 1'b0), "continuous_rearm");
    step(1); upload = 1'b0;

    // Second burst, aborted in the middle of NOTIFY; start is ignored under abort.
    step(30);
    frame = 1'b1;
    expect_at(1, s_cap(8'd1, 1'b0), "burst2_frame1");
    step(1); frame = 1'b0;
    step(30);
    frame = 1'b1;
    expect_at(1, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 3'd2), "notify3_enter");
    step(1); frame = 1'b0;
    step(2);
    abort = 1'b1;
    expect_at(1, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd4), "abort_notify");
    step(1); start = 1'b1;
    step(1); start = 1'b0;
    step(1); abort = 1'b0;
    step(3);

    // Restart, then reset mid-CAPTURE repeats the full settling delay.
    start = 1'b1;
    expect_at(1, s_cap(8'd0, 1'b0), "idle_start2");
    step(1); start = 1'b0;
    step(50);
    rst_n = 1'b0;
    expect_at(1, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0), "reset_mid_capture");
    step(3);
    rst_n = 1'b1;
    expect_at(100, s_cap(8'd0, 1'b0), "startup_exit2");
    step(105);

    tb_done = 1'b1;
  end

endmodule
